// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial sequence-detector controller.
//   state_e   : controller FSM state encoding (also exported on dbg_state)
//   bitcnt_w  : width of the per-word bit counter for a given word width,
//               sized so the counter can hold the value WIDTH itself
// ---------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int STATE_W = 3;

   function automatic int bitcnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear, wins over inc
//   inc      in   add one unless already saturated
//   count_o  out  registered count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
// Feeds WIDTH-bit words MSB first into an external Moore sequence detector
// and counts how many times the detector fires per word and since reset.
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   word offered
//   in_data    in   word to scan, MSB first
//   in_ready   out  controller idle and able to take a word
//   det_clr    out  one-cycle clear to the detector before each word
//   det_din    out  serial bit to the detector
//   det_dout   in   detector output (one cycle behind det_din)
//   hit_count  out  detections in the last completed word (saturating)
//   hit_total  out  detections since reset (saturating)
//   busy       out  word in progress
//   done       out  one-cycle pulse when hit_count is final
//   dbg_state  out  current FSM state (seq_det_pkg::state_e encoding)
//
// Handshake: a word is taken on a rising edge where in_valid=1 and the
// controller is in IDLE (in_ready=1). in_valid is ignored while busy; there
// is no queuing, so the source must hold its word until in_ready is seen.
//
// Timeline from the accepting edge: cycle 1 CLEAR, cycles 2..WIDTH+1 SHIFT,
// cycle WIDTH+2 DRAIN, cycle WIDTH+3 DONE, then IDLE.
// ---------------------------------------------------------------------------
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int TOT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic               det_clr,
   output logic               det_din,
   input  logic               det_dout,
   output logic [CNT_W-1:0]   hit_count,
   output logic [TOT_W-1:0]   hit_total,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] dbg_state
);

   localparam int BC_W = bitcnt_w(WIDTH);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
   localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
   logic             det_din_q, det_din_d;
   logic             det_clr_q, det_clr_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;

   logic             accept;
   logic             sample_en;
   logic             hit;

   // Next-state, datapath and (pre-registered) output logic.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      accept    = 1'b0;
      sample_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept   = 1'b1;
               shreg_d  = in_data;
               bitcnt_d = BC_FULL;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            // The detector is one cycle behind det_din, so the first SHIFT
            // cycle still shows the cleared detector and is not sampled.
            sample_en = (bitcnt_q != BC_FULL);
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d  = bitcnt_q - BC_ONE;
            if (bitcnt_q == BC_ONE) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Picks up the detector's response to the last bit.
            sample_en = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered: compute their value for the coming state.
      // Entering SHIFT from CLEAR the register is unshifted, so the MSB
      // goes out first.
      det_din_d  = (state_d == SHIFT) && shreg_d[WIDTH-1];
      det_clr_d  = (state_d == CLEAR);
      done_d     = (state_d == DONE);
      busy_d     = (state_d != IDLE);
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         det_din_q  <= 1'b0;
         det_clr_q  <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
         det_din_q  <= det_din_d;
         det_clr_q  <= det_clr_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
      end
   end

   // det_dout outside the sampling window is a don't-care.
   assign hit = sample_en && det_dout;

   sat_counter #(.WIDTH(CNT_W)) u_hit_count (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .inc     (hit),
      .count_o (hit_count)
   );

   sat_counter #(.WIDTH(TOT_W)) u_hit_total (
      .clk     (clk),
      .rst     (rst),
      .clr     (1'b0),
      .inc     (hit),
      .count_o (hit_total)
   );

   assign in_ready  = in_ready_q;
   assign det_clr   = det_clr_q;
   assign det_din   = det_din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per input word (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of per-word hit counter.
REQ-003 SHALL have parameter TOT_W, default 16, meaning width of running total hit counter.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  word offered.
REQ-007 SHALL have port in_data  input  WIDTH  word to scan, MSB first.
REQ-008 SHALL have port in_ready  output  1  controller can accept a word.
REQ-009 SHALL have port det_clr  output  1  active-high one-cycle clear to the Moore detector.
REQ-010 SHALL have port det_din  output  1  serial bit to detector Din.
REQ-011 SHALL have port det_dout  input  1  Moore detector Dout.
REQ-012 SHALL have port hit_count  output  CNT_W  detections in last completed word.
REQ-013 SHALL have port hit_total  output  TOT_W  detections since reset.
REQ-014 SHALL have port busy  output  1  word in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse: hit_count valid and updated.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, SHIFT, DRAIN, DONE.
REQ-017 IDLE: in_ready=1, busy=0, det_din=0; on in_valid=1 at clk edge, SHALL capture in_data, clear hit_count, load bit counter WIDTH, go CLEAR.
REQ-018 CLEAR: exactly one cycle, det_clr=1, det_din=0, no sampling; go SHIFT.
REQ-019 SHIFT: det_din = current shift-register MSB; register shifts left by one per cycle; exactly WIDTH cycles; then DRAIN.
REQ-020 Sampling: det_dout SHALL be sampled in SHIFT cycles 2..WIDTH and in DRAIN (exactly WIDTH samples; one-cycle Moore latency).
REQ-021 Each sample with det_dout=1 SHALL increment hit_count and hit_total by one.
REQ-022 hit_count and hit_total SHALL saturate at all-ones, never wrap.
REQ-023 DRAIN: one cycle, det_din=0, final sample; go DONE.
REQ-024 DONE: done=1 for one cycle, hit_count stable; go IDLE.
REQ-025 busy=1 and in_ready=0 in every state except IDLE; in_valid ignored while busy (no queuing).
REQ-026 Back-to-back: new word accepted in first IDLE cycle after DONE; word-to-word period WIDTH+4 cycles.
REQ-027 Latency: done asserts in cycle WIDTH+3 after accepting edge (cycle 11 for WIDTH=8).
REQ-028 hit_count SHALL hold its value from DONE until next acceptance.
REQ-029 det_dout SHALL be ignored outside sampling cycles (glitches in IDLE/CLEAR/DONE have no effect).

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, shift register 0, bit counter 0, hit_count 0, hit_total 0, done 0, det_clr 0, det_din 0, busy 0, in_ready 1 after release.
REQ-031 rst asserted mid-word SHALL abort word with no done pulse; first post-reset word starts with CLEAR.
REQ-032 All outputs SHALL be registered; reset release is synchronous to clk in practice, with no extra delay state.

Structure
REQ-033 FSM state encoding and bit-counter width SHALL live in shared package seq_det_pkg.
REQ-034 Saturating counter SHALL be one sub-module sat_counter (params width; inputs clr, inc), instantiated twice.
REQ-035 Detector is external; controller SHALL NOT contain detector logic.

Verification
REQ-036 Bench SHALL pair DUT with Moore overlapping "101" detector model, clock period 20 ns.
REQ-037 in_data=8'b01010101 -> done in cycle 11 after acceptance, hit_count=3, hit_total=3.
REQ-038 in_data=8'b11111111 then 8'b00000000 back-to-back -> hit_count 0 both, second accepted WIDTH+4 cycles after first, hit_total unchanged.
REQ-039 in_data=8'b10000101 preceded by word ending "10" -> hit_count=1 (CLEAR prevents cross-word match).
REQ-040 rst=0 at SHIFT cycle 4 -> no done pulse, all outputs reset values, next word 8'b10101010 -> hit_count=3.
REQ-041 CNT_W=2, in_data=8'b10101010 with WIDTH=8 -> hit_count saturates at 3; in_valid held high while busy -> no extra acceptance.
